// File: rtl/fp32_div_pkg.sv
// Shared types and constants for the sequential FP32 divider.
// Latency: n/a (package). Backpressure: n/a.
// Backpressure: n/a.
package fp32_div_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int QBITS  = 26;

    localparam logic [31:0] QNAN_C = 32'h7FC0_0000;
    localparam logic [31:0] INF_C  = 32'h7F80_0000;

    typedef enum logic [2:0] {IDLE, UNPACK, DIV, PACK, DONE} state_t;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Exponent field of zero covers true zeros and flushed denormals.
    function automatic cls_t classify(input fp32_t x);
        cls_t c;
        if (x.exp == '0)
            c = ZERO;
        else if (x.exp == '1)
            c = (x.frac != '0) ? NAN : INF;
        else
            c = NORM;
        return c;
    endfunction

endpackage

// File: rtl/fp32_div_step.sv
// One restoring shift-subtract step: produces a quotient bit and the next partial remainder.
// Latency: combinational.
// Backpressure: none.
module fp32_div_step (
    input  logic [24:0] r,
    input  logic [23:0] d,
    input  logic        qbit_in,
    output logic [24:0] r_next,
    output logic        q
);

    logic [24:0] sel;

    // The kept remainder is always below d, so the shift cannot lose a set bit.
    always_comb begin
        q      = (r >= {1'b0, d});
        sel    = q ? (r - {1'b0, d}) : r;
        r_next = (sel << 1) | {24'b0, qbit_in};
    end

endmodule

// File: rtl/fp32_div_seq.sv
// Iterative FP32 divider F = A / B; FP32_DIV_RNE_EN selects round-to-nearest-even, else truncate.
// Latency: 26/STEPS_PER_CYCLE + 2 edges from accept to out_valid, identical for all operand classes.
// Backpressure: one divide in flight; in_ready only when idle, result held in DONE until out_ready.
import fp32_div_pkg::*;

module fp32_div_seq #(
    parameter int          STEPS_PER_CYCLE = 1,
    parameter logic [31:0] QNAN            = QNAN_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] F,
    output logic        dz
);

    localparam int         N    = QBITS / STEPS_PER_CYCLE;
    localparam logic [4:0] LAST = 5'(N - 1);

    state_t             state_q, state_d;
    fp32_t              a_q, b_q;
    cls_t               cls_a_q, cls_b_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        dvsr_q;
    logic [24:0]        rem_q;
    logic [QBITS-1:0]   quo_q;
    logic [4:0]         cnt_q;
    logic [31:0]        f_q;
    logic               dz_q;

    logic [24:0]                r_chain [0:STEPS_PER_CYCLE];
    logic [STEPS_PER_CYCLE-1:0] q_chain;

    assign r_chain[0] = rem_q;

    // First step in the chain yields the most significant quotient bit.
    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
        fp32_div_step u_step (
            .r       (r_chain[i]),
            .d       (dvsr_q),
            .qbit_in (1'b0),
            .r_next  (r_chain[i+1]),
            .q       (q_chain[STEPS_PER_CYCLE-1-i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = UNPACK;
            end
            UNPACK: state_d = DIV;
            DIV:    if (cnt_q == LAST) state_d = PACK;
            PACK:   state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [22:0]       frac_t, frac_fin;
    logic [23:0]       frac_sum;
    logic              rnd, sticky, inc;
    logic signed [9:0] e_adj, e_fin;
    logic [31:0]       res_f;
    logic              res_dz;

    always_comb begin
        e_adj  = exp_q;
        if (quo_q[25]) begin
            frac_t = quo_q[24:2];
            rnd    = quo_q[1];
            sticky = quo_q[0] | (|rem_q);
        end else begin
            frac_t = quo_q[23:1];
            rnd    = quo_q[0];
            sticky = |rem_q;
            e_adj  = exp_q - 10'sd1;
        end
`ifdef FP32_DIV_RNE_EN
        inc = rnd & (sticky | frac_t[0]);
`else
        inc = 1'b0 & rnd & sticky;  // guard bits discarded when truncating
`endif
        frac_sum = {1'b0, frac_t} + {23'b0, inc};
        frac_fin = frac_sum[22:0];
        e_fin    = e_adj;
        if (frac_sum[23]) begin
            frac_fin = '0;
            e_fin    = e_adj + 10'sd1;
        end

        res_dz = 1'b0;
        if (cls_a_q == NAN || cls_b_q == NAN ||
            (cls_a_q == ZERO && cls_b_q == ZERO) ||
            (cls_a_q == INF && cls_b_q == INF))
            res_f = QNAN;
        else if (cls_a_q == INF)
            res_f = INF_C | {sign_q, 31'b0};
        else if (cls_b_q == INF)
            res_f = {sign_q, 31'b0};
        else if (cls_b_q == ZERO) begin
            res_f  = INF_C | {sign_q, 31'b0};
            res_dz = 1'b1;
        end else if (cls_a_q == ZERO)
            res_f = {sign_q, 31'b0};
        else if (e_fin >= 10'sd255)
            res_f = INF_C | {sign_q, 31'b0};
        else if (e_fin <= 10'sd0)
            res_f = {sign_q, 31'b0};
        else
            res_f = {sign_q, e_fin[7:0], frac_fin};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            cls_a_q <= ZERO;
            cls_b_q <= ZERO;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            f_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q <= A;
                    b_q <= B;
                end
                UNPACK: begin
                    cls_a_q <= classify(a_q);
                    cls_b_q <= classify(b_q);
                    sign_q  <= a_q.sign ^ b_q.sign;
                    exp_q   <= $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp}) + 10'sd127;
                    dvsr_q  <= {1'b1, b_q.frac};
                    rem_q   <= {2'b01, a_q.frac};
                    quo_q   <= '0;
                    cnt_q   <= '0;
                end
                DIV: begin
                    rem_q <= r_chain[STEPS_PER_CYCLE];
                    quo_q <= {quo_q[QBITS-1-STEPS_PER_CYCLE:0], q_chain};
                    cnt_q <= cnt_q + 5'd1;
                end
                PACK: begin
                    f_q  <= res_f;
                    dz_q <= res_dz;
                end
                default: ;
            endcase
        end
    end

    assign F  = f_q;
    assign dz = dz_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: scoreboard of expected results keyed at accept.
// Covers reset state, normal/special/overflow/underflow vectors, backpressure and mid-divide reset.
module tb_fp32_div_seq;

    localparam int STEPS = 1;
    localparam int LAT   = 26 / STEPS + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] F;
    logic        dz;

    always #5 clk = ~clk;

    fp32_div_seq #(.STEPS_PER_CYCLE(STEPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .dz        (dz)
    );

    typedef struct {
        logic [31:0] f;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          rise_cyc = 0;
    logic        prev_ov = 1'b0;
    logic [31:0] cur_f = '0;
    logic        cur_dz = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, pushes on accept, pops on result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) rise_cyc = cyc;
                prev_ov = out_valid;
                if (in_valid && in_ready) begin
                    sb.push_back('{cur_f, cur_dz, cyc + 1});
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", F, 32'hxxxx_xxxx);
                    end else begin
                        e = sb.pop_front();
                        chk("F", F, e.f);
                        chk("dz", {31'b0, dz}, {31'b0, e.dz});
                        chk("latency", 32'(rise_cyc - e.acc), 32'(LAT));
                    end
                end
            end
        end
    end

    task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ef, input logic edz);
        int t;
        @(posedge clk); #1;
        A = a; B = b; cur_f = ef; cur_dz = edz; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ef, input logic edz);
        start_div(a, b, ef, edz);
        wait_drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int acc0;
        logic [31:0] third, two_third;
`ifdef FP32_DIV_RNE_EN
        third     = 32'h3EAA_AAAB;
        two_third = 32'h3F2A_AAAB;
`else
        third     = 32'h3EAA_AAAA;
        two_third = 32'h3F2A_AAAA;
`endif
        #1;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_F",         F,                  32'd0);
        chk("rst_dz",        {31'b0, dz},        32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        do_div(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 1'b0);
        do_div(32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 1'b0);
        do_div(32'h3F80_0000, 32'h4040_0000, third,         1'b0);
        do_div(32'h4000_0000, 32'h4040_0000, two_third,     1'b0);
        do_div(32'h4120_0000, 32'h4080_0000, 32'h4020_0000, 1'b0);
        do_div(32'hC040_0000, 32'h4000_0000, 32'hBFC0_0000, 1'b0);
        do_div(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        do_div(32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1);
        do_div(32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 1'b1);
        do_div(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0);
        do_div(32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 1'b0);
        do_div(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0);
        do_div(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
        do_div(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
        do_div(32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0);
        do_div(32'h8000_0000, 32'hC000_0000, 32'h0000_0000, 1'b0);
        do_div(32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0);
        do_div(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0);
        do_div(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0);

        // Backpressure: result held, no second accept while out_ready is low.
        out_ready = 1'b0;
        start_div(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 1'b0);
        acc0 = n_acc;
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        A = 32'h3F80_0000; B = 32'h3F80_0000;
        cur_f = 32'h3F80_0000; cur_dz = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_F",        F,                  32'h4000_0000);
            chk("bp_dz",       {31'b0, dz},        32'd0);
            chk("bp_in_ready", {31'b0, in_ready},  32'd0);
        end
        chk("bp_no_accept", 32'(n_acc), 32'(acc0));
        out_ready = 1'b1;
        t = 0;
        while (!in_ready && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_release_idle", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
        chk("bp_accepts", 32'(n_acc), 32'(acc0 + 1));

        // Reset in the middle of the iteration discards the divide.
        start_div(32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 1'b0);
        repeat (11) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_F",         F,                  32'd0);
        chk("mid_rst_dz",        {31'b0, dz},        32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        do_div(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 1'b0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
